// File: rtl/rv_mem_pkg.sv
// -----------------------------------------------------------------------------
// rv_mem_pkg
// Shared definitions for the RISC-V memory access controller:
//   - mem_sm_type : controller FSM state encoding (IDLE, REQ, RDATA, DONE)
//   - DEF_TIMEOUT : default watchdog limit in cycles
//   - DEF_CNT_W   : default watchdog counter width
// Build option: RV_MEM_TIMEOUT_EN (consumed by rv_mem_ctl) enables the watchdog.
// -----------------------------------------------------------------------------
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } mem_sm_type;

    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned DEF_CNT_W   = 8;

endpackage : rv_mem_pkg

// File: rtl/rv_mem_wdog.sv
// -----------------------------------------------------------------------------
// rv_mem_wdog
// Handshake watchdog: counts cycles spent waiting in a memory wait state and
// flags expiry once the count reaches TIMEOUT.
// Only instantiated when RV_MEM_TIMEOUT_EN is defined.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low
//   clr_i     in   clear counter (asserted on the edge entering a wait state)
//   en_i      in   currently in a wait state; count advances each cycle
//   expire_o  out  count has reached TIMEOUT while enabled
// -----------------------------------------------------------------------------
module rv_mem_wdog
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over count so re-entry into a wait state starts from zero;
    // the count parks at LIMIT since the FSM leaves on expiry anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LIMIT);

endmodule : rv_mem_wdog

// File: rtl/rv_mem_ctl.sv
// -----------------------------------------------------------------------------
// rv_mem_ctl
// Memory access controller between the multicycle RISC-V core and an external
// word memory with a variable-latency req/gnt/rvalid handshake. One load or
// store is accepted in IDLE, the request is latched, the memory handshake is
// driven, and completion is signalled with a one-cycle cpu_done pulse
// (cpu_err qualifies it). Load data is held in cpu_rdata until the next load.
//
// Build option: RV_MEM_TIMEOUT_EN -- adds a watchdog (rv_mem_wdog) that aborts
// a REQ/RDATA wait after TIMEOUT cycles with an error completion. Without it
// the FSM waits indefinitely and cpu_err reports misalignment only.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active-low
//   cpu_req     in   start access (sampled in IDLE only)
//   cpu_we      in   1 = store, 0 = load
//   cpu_addr    in   [31:0] byte address (must be word aligned)
//   cpu_wdata   in   [31:0] store data
//   cpu_rdata   out  [31:0] last load result
//   cpu_busy    out  access in progress (REQ/RDATA)
//   cpu_done    out  one-cycle completion pulse
//   cpu_err     out  error completion (misaligned or watchdog abort)
//   mem_req     out  memory request
//   mem_we      out  latched write enable
//   mem_addr    out  [29:0] latched word address
//   mem_wdata   out  [31:0] latched store data
//   mem_gnt     in   request accepted this cycle
//   mem_rvalid  in   read data valid (honoured in RDATA only)
//   mem_rdata   in   [31:0] read data
// -----------------------------------------------------------------------------
module rv_mem_ctl
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Reject a watchdog limit that the counter cannot represent.
    if (TIMEOUT >= (64'd1 << CNT_W)) begin : g_cfg_check
        $error("rv_mem_ctl: TIMEOUT must be below 2**CNT_W");
    end

    mem_sm_type  state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [29:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] cpu_rdata_q;
    logic        cpu_busy_q;
    logic        cpu_done_q;
    logic        cpu_err_q;

    logic        aligned;
    logic        wd_expire;

    assign aligned = (cpu_addr[1:0] == 2'b00);

`ifdef RV_MEM_TIMEOUT_EN
    logic wd_clr;
    logic wd_en;

    // Clear on the edges that enter REQ (aligned acceptance) or RDATA
    // (load grant); count while waiting in either state.
    assign wd_clr = ((state_q == IDLE) && cpu_req && aligned) ||
                    ((state_q == REQ) && mem_gnt && !mem_we_q);
    assign wd_en  = (state_q == REQ) || (state_q == RDATA);

    rv_mem_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    // Outputs are registered alongside the state so they reflect it exactly.
    // A handshake is tested before expiry so it wins on the limit cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_busy_q  <= 1'b0;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        mem_we_q    <= cpu_we;
                        mem_addr_q  <= cpu_addr[31:2];
                        mem_wdata_q <= cpu_wdata;
                        if (aligned) begin
                            state_q    <= REQ;
                            mem_req_q  <= 1'b1;
                            cpu_busy_q <= 1'b1;
                        end else begin
                            // Misaligned: complete with error, no memory cycle.
                            state_q    <= DONE;
                            cpu_done_q <= 1'b1;
                            cpu_err_q  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q    <= DONE;
                            cpu_busy_q <= 1'b0;
                            cpu_done_q <= 1'b1;
                        end else begin
                            state_q <= RDATA;
                        end
                    end else if (wd_expire) begin
                        state_q    <= DONE;
                        mem_req_q  <= 1'b0;
                        cpu_busy_q <= 1'b0;
                        cpu_done_q <= 1'b1;
                        cpu_err_q  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (mem_rvalid) begin
                        state_q     <= DONE;
                        cpu_rdata_q <= mem_rdata;
                        cpu_busy_q  <= 1'b0;
                        cpu_done_q  <= 1'b1;
                    end else if (wd_expire) begin
                        state_q    <= DONE;
                        cpu_busy_q <= 1'b0;
                        cpu_done_q <= 1'b1;
                        cpu_err_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    cpu_done_q <= 1'b0;
                    cpu_err_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    mem_req_q  <= 1'b0;
                    cpu_busy_q <= 1'b0;
                    cpu_done_q <= 1'b0;
                    cpu_err_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_busy  = cpu_busy_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_err   = cpu_err_q;

endmodule : rv_mem_ctl

// File: tb/tb_rv_mem_ctl.sv
// -----------------------------------------------------------------------------
// tb_rv_mem_ctl
// Self-checking bench for rv_mem_ctl. Each scenario task drives the core and
// memory sides and checks outputs inline; expected completions (error flag,
// read data, completion cycle) are queued when an access is launched and
// compared by a monitor whenever cpu_done pulses.
// Cycle numbering: cycle 0 ends with the acceptance edge, cycle 1 follows it.
// -----------------------------------------------------------------------------
module tb_rv_mem_ctl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    rv_mem_ctl #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_busy   (cpu_busy),
        .cpu_done   (cpu_done),
        .cpu_err    (cpu_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_rdata = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Completion monitor: every cpu_done must match the oldest queued entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && cpu_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: done at cyc=%0d, none expected", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                checks++;
                if (cpu_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL done_err: got %0b expected %0b", cpu_err, mon_e.err);
                end
                checks++;
                if (cpu_rdata !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL done_rdata: got %08h expected %08h", cpu_rdata, mon_e.rdata);
                end
                checks++;
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got cyc=%0d expected cyc=%0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, cpu_busy, cpu_done, cpu_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/busy/done/err=%05b expected 00000",
                     {mem_req, mem_we, cpu_busy, cpu_done, cpu_err});
        end
        checks++;
        if (mem_addr !== 30'h0 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected all 0",
                     mem_addr, mem_wdata, cpu_rdata);
        end
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_store();
        int base = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        sb_q.push_back('{err: 1'b0, rdata: exp_rdata, cyc: base + 2});
        next_cycle();
        cpu_req = 1'b0; cpu_wdata = 32'h0; mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || cpu_busy !== 1'b1) begin
            errors++;
            $display("FAIL store_req: req=%b busy=%b expected 1 1", mem_req, cpu_busy);
        end
        checks++;
        if (mem_addr !== 30'h4 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_latch: addr=%h we=%b wdata=%h expected 4 1 deadbeef",
                     mem_addr, mem_we, mem_wdata);
        end
        next_cycle();
        mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_done !== 1'b1 || mem_req !== 1'b0 || cpu_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL store_done: done=%b req=%b rdata=%h expected 1 0 %h",
                     cpu_done, mem_req, cpu_rdata, exp_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_done !== 1'b0 || cpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL store_idle: done=%b busy=%b expected 0 0", cpu_done, cpu_busy);
        end
        next_cycle();
    endtask

    task automatic test_load();
        int base = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_wdata = 32'h0;
        sb_q.push_back('{err: 1'b0, rdata: 32'h12345678, cyc: base + 8});
        next_cycle();
        cpu_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            // rvalid alongside the grant (k==4) carries junk and must be ignored.
            mem_gnt    = (k == 4);
            mem_rvalid = (k == 4) || (k == 7);
            mem_rdata  = (k == 7) ? 32'h12345678 : 32'hBAD0BAD0;
            @(negedge clk);
            if (k <= 7) begin
                checks++;
                if (cpu_busy !== 1'b1 || mem_req !== (k <= 4)) begin
                    errors++;
                    $display("FAIL load_wait k=%0d: busy=%b req=%b expected 1 %b",
                             k, cpu_busy, mem_req, (k <= 4));
                end
            end
            if (k == 1) begin
                checks++;
                if (mem_addr !== 30'h8 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL load_latch: addr=%h we=%b expected 8 0", mem_addr, mem_we);
                end
            end
            if (k == 7) begin
                checks++;
                if (cpu_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL load_early_rdata: got %h expected %h", cpu_rdata, exp_rdata);
                end
            end
            if (k == 8) begin
                checks++;
                if (cpu_done !== 1'b1 || cpu_busy !== 1'b0 || cpu_rdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL load_done: done=%b busy=%b rdata=%h expected 1 0 12345678",
                             cpu_done, cpu_busy, cpu_rdata);
                end
            end
            next_cycle();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_rdata = 32'h12345678;
    endtask

    task automatic test_misaligned();
        int base = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3;
        sb_q.push_back('{err: 1'b1, rdata: exp_rdata, cyc: base + 1});
        next_cycle();
        cpu_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL misalign_req k=%0d: got %b expected 0", k, mem_req);
            end
            if (k == 1) begin
                checks++;
                if (cpu_done !== 1'b1 || cpu_err !== 1'b1) begin
                    errors++;
                    $display("FAIL misalign_done: done=%b err=%b expected 1 1", cpu_done, cpu_err);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [3];
        logic [31:0] ad [3];
        logic [29:0] ad_w;
        int base = cyc;
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
        ad[0] = 32'h100;      ad[1] = 32'h104;      ad[2] = 32'h108;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ad[0]; cpu_wdata = wd[0];
        mem_gnt = 1'b1;
        for (int j = 0; j < 3; j++)
            sb_q.push_back('{err: 1'b0, rdata: exp_rdata, cyc: base + 2 + 3 * j});
        next_cycle();
        for (int k = 1; k <= 9; k++) begin
            int j = (k - 1) / 3;
            int ph = (k - 1) % 3;
            if (ph == 0) begin
                // Change the core inputs while the latched copy is in use.
                if (j < 2) begin
                    cpu_addr = ad[j + 1]; cpu_wdata = wd[j + 1];
                end else begin
                    cpu_req = 1'b0; cpu_wdata = 32'hFFFFFFFF;
                end
            end
            @(negedge clk);
            if (ph == 0) begin
                ad_w = ad[j][31:2];
                checks++;
                if (mem_req !== 1'b1 || mem_wdata !== wd[j] || mem_addr !== ad_w) begin
                    errors++;
                    $display("FAIL b2b_req j=%0d: req=%b wdata=%h addr=%h expected 1 %h %h",
                             j, mem_req, mem_wdata, mem_addr, wd[j], ad_w);
                end
            end else if (ph == 1) begin
                checks++;
                if (cpu_done !== 1'b1 || cpu_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_done j=%0d: done=%b busy=%b expected 1 0", j, cpu_done, cpu_busy);
                end
            end else begin
                checks++;
                if (mem_req !== 1'b0 || cpu_busy !== 1'b0 || cpu_done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle j=%0d: req=%b busy=%b done=%b expected 0 0 0",
                             j, mem_req, cpu_busy, cpu_done);
                end
            end
            next_cycle();
        end
        mem_gnt = 1'b0; cpu_wdata = '0;
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        next_cycle();
        cpu_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: got %b expected 1", mem_req);
        end
        next_cycle();
        mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_busy !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_rdata_state: busy=%b req=%b expected 1 0", cpu_busy, mem_req);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_busy !== 1'b0 || mem_addr !== 30'h0) begin
            errors++;
            $display("FAIL rstmid_async: req=%b busy=%b addr=%h expected 0 0 0",
                     mem_req, cpu_busy, mem_addr);
        end
        next_cycle();
        rst = 1'b1;
        exp_rdata = 32'h0;
        mem_rvalid = 1'b1; mem_rdata = 32'h00BADBAD;
        next_cycle();
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_done !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 32'h0) begin
                errors++;
                $display("FAIL rstmid_late_rvalid k=%0d: done=%b busy=%b rdata=%h expected 0 0 0",
                         k, cpu_done, cpu_busy, cpu_rdata);
            end
            next_cycle();
        end
    endtask

`ifdef RV_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int base = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        sb_q.push_back('{err: 1'b1, rdata: exp_rdata, cyc: base + 6});
        next_cycle();
        cpu_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (k <= 5 && (mem_req !== 1'b1 || cpu_busy !== 1'b1)) begin
                errors++;
                $display("FAIL timeout_wait k=%0d: req=%b busy=%b expected 1 1", k, mem_req, cpu_busy);
            end else if (k == 6 && (cpu_done !== 1'b1 || cpu_err !== 1'b1 || mem_req !== 1'b0)) begin
                errors++;
                $display("FAIL timeout_done: done=%b err=%b req=%b expected 1 1 0",
                         cpu_done, cpu_err, mem_req);
            end
            next_cycle();
        end
        next_cycle();
        // Grant on the limit cycle completes normally.
        base = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h84; cpu_wdata = 32'hA5A5A5A5;
        sb_q.push_back('{err: 1'b0, rdata: exp_rdata, cyc: base + 6});
        next_cycle();
        cpu_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            mem_gnt = (k == 5);
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (cpu_done !== 1'b1 || cpu_err !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_race: done=%b err=%b expected 1 0", cpu_done, cpu_err);
                end
            end
            next_cycle();
        end
        mem_gnt = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h88; cpu_wdata = 32'h5A5A5A5A;
        next_cycle();
        cpu_req = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_busy !== 1'b1 || mem_req !== 1'b1 || cpu_done !== 1'b0) begin
                errors++;
                if (bad < 5)
                    $display("FAIL nowdog_wait k=%0d: busy=%b req=%b done=%b expected 1 1 0",
                             k, cpu_busy, mem_req, cpu_done);
                bad++;
            end
            next_cycle();
        end
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        exp_rdata = 32'h0;
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
`ifdef RV_MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (3) next_cycle();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d completions outstanding, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rv_mem_ctl
